mult_handshake: RTL and testbench
=================================

# mult_handshake

Operand/result handshake stage wrapped around the Booth sequential multiplier. Accepts a signed operand pair over a valid/ready source interface, holds it stable, pulses the multiplier's start input, waits for its done pulse, then presents the registered product over a valid/ready destination interface. A busy-cycle watchdog flags a multiplier that never completes.

## Interface
- WIDTH, 16: operand width in bits; product is 2*WIDTH.
- TIMEOUT, 2*WIDTH+4: BUSY cycles allowed before the watchdog fires; must be > WIDTH+2.

- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; one clock domain only.
- src_valid  in  1  operand pair valid.
- src_ready  out  1  stage can accept operands.
- src_a  in  WIDTH  signed multiplicand.
- src_b  in  WIDTH  signed multiplier.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_a  out  WIDTH  registered multiplicand, held stable from START until result capture.
- mult_b  out  WIDTH  registered multiplier, same hold rule.
- mult_done  in  1  multiplier completion pulse.
- mult_product  in  2*WIDTH  multiplier result, sampled only when mult_done=1.
- dst_valid  out  1  result valid.
- dst_ready  in  1  consumer accepts result.
- dst_product  out  2*WIDTH  registered signed product.
- dst_err  out  1  result was produced by watchdog timeout; dst_product=0 in that case.

## Operation
- States: IDLE, START, BUSY, HOLD.
- IDLE: src_ready=1. On src_valid (fire): register src_a/src_b into mult_a/mult_b, go START.
- START: mult_start=1 for exactly this cycle; clear watchdog counter; go BUSY.
- BUSY: counter increments each cycle. On mult_done=1: register mult_product into dst_product, dst_err=0, go HOLD. Else if counter reaches TIMEOUT-1: dst_product=0, dst_err=1, go HOLD.
- HOLD: dst_valid=1; dst_product/dst_err stable. On dst_ready=1: go IDLE.
- src_ready is 1 only in IDLE; no operand accepted in START/BUSY/HOLD.
- mult_done outside BUSY is ignored (no state or output change).
- mult_done and watchdog expiry in the same cycle: mult_done wins, dst_err=0.
- Product is passed through unmodified; no sign extension or truncation inside this block.
- dst_valid must not drop before dst_ready is seen; dst_product must not change while dst_valid=1.

## Timing
- Reset (rst=0, asynchronous): state IDLE; src_ready=1 after reset release (combinational from state), mult_start=0, mult_a=0, mult_b=0, dst_valid=0, dst_product=0, dst_err=0, counter=0.
- Reset asserted mid-operation (any state): immediate return to IDLE with the above values; in-flight result discarded.
- Source fire at edge N -> mult_start high during cycle N+1 -> BUSY from N+2.
- mult_done high during cycle M -> dst_valid high from cycle M+1.
- Result handshake completes on the edge where dst_valid=1 and dst_ready=1; src_ready=1 the next cycle. Minimum wrapper overhead per operation: 3 cycles beyond multiplier latency.
- mult_start, src_ready, dst_valid are decoded from state only (Moore); no combinational path from src_valid/dst_ready/mult_done to any output.

## Structure
- Shared package mult_pkg: state enum type (IDLE, START, BUSY, HOLD), default WIDTH constant, product-width constant 2*WIDTH.
- Single module; the watchdog counter (clog2(TIMEOUT) bits) lives inline. No sub-module needed.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs at reset values; after release src_ready=1, dst_valid=0.
- Basic: WIDTH=16, src_a=3, src_b=-5 with model multiplier -> one mult_start pulse, mult_a/mult_b stable until done, dst_product=32'hFFFF_FFF1, dst_err=0.
- Backpressure: dst_ready=0 for 10 cycles after dst_valid -> dst_product stable, src_ready=0 throughout, src_valid ignored; completes on dst_ready=1.
- Timeout: model never asserts mult_done -> dst_valid after exactly TIMEOUT BUSY cycles, dst_product=0, dst_err=1.
- Spurious done: mult_done pulsed in IDLE and HOLD -> no state or output change; done coincident with timeout -> dst_err=0, real product.
- Mid-op reset: assert rst=0 during BUSY -> immediate IDLE, dst_valid=0; next operation (-32768 x -32768) -> dst_product=32'h4000_0000.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the Booth multiplier handshake wrapper.
// Provides the stage FSM encoding and the default operand/product widths.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 16;

   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

   localparam int DEF_PROD_WIDTH = prod_width(DEF_WIDTH);

endpackage

// File: rtl/mult_handshake.sv
// Valid/ready operand and result stage around a sequential multiplier,
// with a busy-cycle watchdog that returns an error result on a stalled multiplier.
module mult_handshake
   import mult_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = 2 * WIDTH + 4,
   localparam int PW     = prod_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             mult_start,
   output logic [WIDTH-1:0] mult_a,
   output logic [WIDTH-1:0] mult_b,
   input  logic             mult_done,
   input  logic [PW-1:0]    mult_product,
   output logic             dst_valid,
   input  logic             dst_ready,
   output logic [PW-1:0]    dst_product,
   output logic             dst_err
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state_r;
   state_t             state_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   mult_a_r;
   logic [WIDTH-1:0]   mult_b_r;
   logic [PW-1:0]      product_r;
   logic               err_r;
   logic               expired_s;

   assign expired_s = (cnt_r == TO_LAST);

   // Next-state decode; done takes priority over watchdog expiry
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (src_valid) state_s = START;
            else           state_s = IDLE;
         end
         START: state_s = BUSY;
         BUSY: begin
            if (mult_done || expired_s) state_s = HOLD;
            else                        state_s = BUSY;
         end
         HOLD: begin
            if (dst_ready) state_s = IDLE;
            else           state_s = HOLD;
         end
         default: state_s = IDLE;
      endcase
   end

   // State, operand, watchdog and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         mult_a_r  <= '0;
         mult_b_r  <= '0;
         product_r <= '0;
         err_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (src_valid) begin
                  mult_a_r <= src_a;
                  mult_b_r <= src_b;
               end
            end
            START: cnt_r <= '0;
            BUSY: begin
               cnt_r <= cnt_r + CNT_W'(1);
               if (mult_done) begin
                  product_r <= mult_product;
                  err_r     <= 1'b0;
               end else if (expired_s) begin
                  product_r <= '0;
                  err_r     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake strobes are pure Moore decodes of the state register
   assign src_ready   = (state_r == IDLE);
   assign mult_start  = (state_r == START);
   assign dst_valid   = (state_r == HOLD);
   assign mult_a      = mult_a_r;
   assign mult_b      = mult_b_r;
   assign dst_product = product_r;
   assign dst_err     = err_r;

endmodule

// File: tb/tb_mult_handshake.sv
// Directed self-checking bench for mult_handshake with a behavioural multiplier
// model and a scoreboard of expected {err, product} results.
module tb_mult_handshake;
   import mult_pkg::*;

   localparam int W  = 16;
   localparam int PW = 2 * W;
   localparam int TO = 2 * W + 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          src_valid, src_ready;
   logic [W-1:0]  src_a, src_b;
   logic          mult_start, mult_done;
   logic [W-1:0]  mult_a, mult_b;
   logic [PW-1:0] mult_product;
   logic          dst_valid, dst_ready, dst_err;
   logic [PW-1:0] dst_product;

   int checks = 0;
   int errors = 0;
   logic [PW:0] exp_q[$];
   int start_cnt = 0;

   int            mdl_lat = 3;
   bit            mdl_never = 1'b0;
   bit            rnd_mode = 1'b0;
   bit            spur = 1'b0;
   logic [PW-1:0] spur_val = 32'hDEAD_BEEF;
   int            cd = 0;
   logic [PW-1:0] mdl_p = '0;

   always #5 clk = ~clk;

   mult_handshake #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
      .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_done(mult_done), .mult_product(mult_product),
      .dst_valid(dst_valid), .dst_ready(dst_ready),
      .dst_product(dst_product), .dst_err(dst_err)
   );

   // Behavioural multiplier: done pulse mdl_lat cycles after the start cycle
   initial begin
      mult_done = 1'b0;
      mult_product = '0;
      forever begin
         @(posedge clk); #2;
         if (rnd_mode) begin
            mult_done = 1'($urandom);
            mult_product = PW'($urandom);
            cd = 0;
         end else begin
            mult_done = 1'b0;
            mult_product = '0;
            if (mult_start === 1'b1) begin
               cd = mdl_lat;
               mdl_p = $signed(mult_a) * $signed(mult_b);
            end else if (cd > 0) begin
               cd--;
               if (cd == 0 && !mdl_never) begin
                  mult_done = 1'b1;
                  mult_product = mdl_p;
               end
            end
            if (spur) begin
               mult_done = 1'b1;
               mult_product = spur_val;
            end
         end
      end
   end

   always @(negedge clk) if (mult_start === 1'b1) start_cnt++;

   initial begin
      #1000000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "bench timeout");
   end

   function automatic logic [PW-1:0] prod(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      return a * b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit exp_err);
      int n = 0;
      @(negedge clk);
      while (src_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("src_ready_before_send", 64'(src_ready), 64'd1);
      src_valid = 1'b1; src_a = a; src_b = b;
      exp_q.push_back({exp_err, exp_err ? PW'(0) : prod(a, b)});
      @(posedge clk); #1;
      src_valid = 1'b0; src_a = W'($urandom); src_b = W'($urandom);
   endtask

   task automatic wait_valid(input string tag, input int n0, output int lat);
      int n = n0;
      do begin @(negedge clk); n++; end while (dst_valid !== 1'b1 && n < n0 + 200);
      lat = n;
      chk({tag, "_valid"}, 64'(dst_valid), 64'd1);
   endtask

   task automatic take(input string tag);
      logic [PW:0] e;
      chk({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_product"}, 64'(dst_product), 64'(e[PW-1:0]));
         chk({tag, "_err"}, 64'(dst_err), 64'(e[PW]));
      end
      dst_ready = 1'b1;
      @(posedge clk); #1;
      dst_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_after_ready_valid"}, 64'({src_ready, dst_valid}), 64'(2'b10));
   endtask

   initial begin
      int lat, s0;
      logic [PW-1:0] held;
      rst = 1'b0; src_valid = 1'b0; src_a = '0; src_b = '0; dst_ready = 1'b0;
      rnd_mode = 1'b1;
      // reset with random inputs
      repeat (5) begin
         @(posedge clk); #1;
         src_valid = 1'($urandom); src_a = W'($urandom); src_b = W'($urandom);
         dst_ready = 1'($urandom);
         @(negedge clk);
         chk("reset_ctl", 64'({src_ready, mult_start, dst_valid, dst_err}), 64'(4'b1000));
         chk("reset_data", {mult_a, mult_b, dst_product}, 64'h0);
      end
      rnd_mode = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("post_reset", 64'({src_ready, dst_valid}), 64'(2'b10));

      // basic 3 x -5
      mdl_lat = 4; s0 = start_cnt;
      send(16'd3, 16'hFFFB, 1'b0);
      @(negedge clk);
      chk("basic_start", 64'({mult_start, mult_a, mult_b}), 64'({1'b1, 16'd3, 16'hFFFB}));
      wait_valid("basic", 1, lat);
      chk("basic_latency", 64'(lat), 64'(mdl_lat + 2));
      chk("basic_operands_held", 64'({mult_a, mult_b}), 64'({16'd3, 16'hFFFB}));
      chk("basic_const", 64'(dst_product), 64'(32'hFFFF_FFF1));
      take("basic");
      chk("basic_one_start", 64'(start_cnt - s0), 64'd1);

      // spurious done in IDLE
      @(posedge clk); #1; spur = 1'b1;
      @(posedge clk); #1; spur = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("spur_idle", 64'({src_ready, dst_valid, dst_err, dst_product}), 64'({3'b100, 32'hFFFF_FFF1}));

      // backpressure with a spurious done in HOLD
      mdl_lat = 2; s0 = start_cnt;
      send(16'd1234, 16'd77, 1'b0);
      wait_valid("bp", 0, lat);
      held = dst_product;
      for (int i = 0; i < 10; i++) begin
         src_valid = 1'b1; src_a = W'($urandom); src_b = W'($urandom);
         spur = (i == 3);
         @(negedge clk);
         chk("bp_hold", 64'({dst_valid, src_ready, dst_product}), 64'({2'b10, held}));
      end
      src_valid = 1'b0; spur = 1'b0;
      take("bp");
      repeat (3) @(negedge clk);
      chk("bp_no_extra_op", 64'({start_cnt - s0, dst_valid}), 64'({32'd1, 1'b0}));

      // watchdog timeout
      mdl_never = 1'b1;
      send(16'd5, 16'd6, 1'b1);
      wait_valid("timeout", 0, lat);
      chk("timeout_latency", 64'(lat), 64'(TO + 2));
      take("timeout");
      mdl_never = 1'b0;

      // done coincident with expiry, then done one cycle too late
      mdl_lat = TO;
      send(16'hFFF9, 16'd9, 1'b0);
      wait_valid("coincident", 0, lat);
      chk("coincident_latency", 64'(lat), 64'(TO + 2));
      take("coincident");
      mdl_lat = TO + 1;
      send(16'd100, 16'd100, 1'b1);
      wait_valid("late", 0, lat);
      take("late");

      // reset during BUSY
      mdl_never = 1'b1; mdl_lat = 3;
      send(16'd11, 16'd13, 1'b0);
      void'(exp_q.pop_back());
      repeat (5) @(negedge clk);
      chk("busy_before_reset", 64'({src_ready, dst_valid, mult_start}), 64'(3'b000));
      rst = 1'b0; #1;
      chk("midop_reset_ctl", 64'({src_ready, mult_start, dst_valid, dst_err}), 64'(4'b1000));
      chk("midop_reset_data", {mult_a, mult_b, dst_product}, 64'h0);
      @(negedge clk); rst = 1'b1; mdl_never = 1'b0;
      send(16'h8000, 16'h8000, 1'b0);
      wait_valid("minmin", 0, lat);
      chk("minmin_const", 64'(dst_product), 64'(32'h4000_0000));
      take("minmin");
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
